// File: rtl/conv_result_streamer_pkg.sv
// Shared definitions for the Conv2d result streamer: FSM encoding, default
// map geometry and a width helper.
package conv_result_streamer_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   localparam int DEF_N          = 24;
   localparam int DEF_Q          = 12;
   localparam int DEF_H_OUT      = 32;
   localparam int DEF_W_OUT      = 160;
   localparam int DEF_OUTCHANNEL = 64;

   // $clog2 that never yields a zero-width vector.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/conv_result_streamer_pixel_mux.sv
// Selects one N-bit pixel word out of the captured flat map buffer.
module conv_result_streamer_pixel_mux
   import conv_result_streamer_pkg::*;
#(
   parameter int N   = DEF_N,
   parameter int PIX = DEF_H_OUT * DEF_W_OUT,
   parameter int PW  = clog2_min1(PIX)
) (
   input  logic [N*PIX-1:0] buf_i,
   input  logic [PW-1:0]    sel_i,
   output logic [N-1:0]     data_o
);

   // Kept purely combinational; a register here would add one cycle of latency.
   assign data_o = buf_i[N*int'(sel_i) +: N];

endmodule

// File: rtl/conv_result_streamer.sv
// Captures one Conv2d output map from the flat result bus and streams it as
// one pixel per cycle over valid/ready, tracking the output channel index.
module conv_result_streamer
   import conv_result_streamer_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int H_OUT      = DEF_H_OUT,
   parameter int W_OUT      = DEF_W_OUT,
   parameter int OUTCHANNEL = DEF_OUTCHANNEL
) (
   input  logic                                  clk,
   input  logic                                  global_rst,
   input  logic [N*H_OUT*W_OUT-1:0]              result_in,
   input  logic                                  cap_valid,
   output logic                                  cap_ready,
   output logic [N-1:0]                          m_data,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic                                  m_last,
   output logic                                  m_frame_last,
   output logic [clog2_min1(OUTCHANNEL)-1:0]     ch_idx,
   output logic                                  busy
);

   localparam int PIX = H_OUT * W_OUT;
   localparam int PW  = clog2_min1(PIX);
   localparam int CW  = clog2_min1(OUTCHANNEL);

   localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(OUTCHANNEL - 1);

   state_e            state_q, state_d;
   logic [PW-1:0]     pix_q, pix_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [N*PIX-1:0]  buf_q;
   logic [N-1:0]      mux_data;
   logic              hs, last_hs, capture;

   assign m_valid = (state_q == ST_STREAM);
   assign busy    = m_valid;
   assign hs      = m_valid & m_ready;
   assign last_hs = hs & (pix_q == PIX_LAST);

   // cap_valid only gates the capture, never an output, so no comb path leaks.
   assign cap_ready = (state_q == ST_IDLE) | last_hs;
   assign capture   = cap_valid & cap_ready;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      ch_d    = ch_q;
      if (hs) begin
         if (pix_q == PIX_LAST) begin
            pix_d   = '0;
            state_d = ST_IDLE;
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
         end else begin
            pix_d = pix_q + PW'(1);
         end
      end
      if (capture) begin
         state_d = ST_STREAM;
         pix_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         state_q <= ST_IDLE;
         pix_q   <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         ch_q    <= ch_d;
      end
   end

   // Map buffer carries data only; its contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_q <= result_in;
      end
   end

   conv_result_streamer_pixel_mux #(
      .N   (N),
      .PIX (PIX),
      .PW  (PW)
   ) u_pixel_mux (
      .buf_i  (buf_q),
      .sel_i  (pix_q),
      .data_o (mux_data)
   );

   assign m_data       = m_valid ? mux_data : '0;
   assign m_last       = m_valid & (pix_q == PIX_LAST);
   assign m_frame_last = m_last & (ch_q == CH_LAST);
   assign ch_idx       = ch_q;

endmodule
